// File: rtl/strip_check_pkg.sv
// rtl/strip_check_pkg.sv - strip frame checker shared types, widths and test-pattern generator
package strip_check_pkg;

  localparam int FRAME_W   = 104;
  localparam int SEQ_W     = 8;
  localparam int PAY_W     = FRAME_W - SEQ_W;
  localparam int PAY_BYTES = PAY_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Reference frame for a given sequence byte: seq on top, payload byte k = seq+k+1
  function automatic logic [FRAME_W-1:0] expected_frame(input logic [SEQ_W-1:0] seq);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1 -: SEQ_W] = seq;
    for (int k = 0; k < PAY_BYTES; k++) begin
      f[k*8 +: 8] = seq + 8'(k + 1);
    end
    return f;
  endfunction

endpackage

// File: rtl/strip_popcount104.sv
// rtl/strip_popcount104.sv - two-stage registered popcount of a 104-bit vector
module strip_popcount104
  import strip_check_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [FRAME_W-1:0] vec_i,
  output logic [6:0]         cnt_o
);

  localparam int NBYTES = FRAME_W / 8;

  logic [3:0] byte_cnt_d [NBYTES];
  logic [3:0] byte_cnt_q [NBYTES];
  logic [6:0] cnt_d;
  logic [6:0] cnt_q;

  // Per-byte bit counts
  always_comb begin
    for (int b = 0; b < NBYTES; b++) begin
      byte_cnt_d[b] = '0;
      for (int i = 0; i < 8; i++) begin
        byte_cnt_d[b] = byte_cnt_d[b] + {3'b000, vec_i[b*8 + i]};
      end
    end
  end

  // First pipeline stage: register the byte counts
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < NBYTES; b++) byte_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBYTES; b++) byte_cnt_q[b] <= byte_cnt_d[b];
    end
  end

  // Sum of the registered byte counts
  always_comb begin
    cnt_d = '0;
    for (int b = 0; b < NBYTES; b++) begin
      cnt_d = cnt_d + {3'b000, byte_cnt_q[b]};
    end
  end

  // Second pipeline stage: register the total
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/strip_frame_checker.sv
// rtl/strip_frame_checker.sv - strip pattern checker with hunt/lock FSM; bit-error path under STRIP_CHECK_BITERR_EN
module strip_frame_checker
  import strip_check_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk160,
  input  logic               reset,
  input  logic               data_valid,
  input  logic [FRAME_W-1:0] data_in,
  input  logic               clear_cnt,
  output logic [1:0]         state,
  output logic               locked,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        err_frame_cnt,
  output logic [31:0]        bit_err_cnt,
  output logic               timeout,
  output logic [FRAME_W-1:0] last_err_frame
);

  localparam int unsigned      TO_W        = $clog2(TIMEOUT);
  localparam logic [3:0]       LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0]       UNLOCK_LAST = 4'(UNLOCK_CNT - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              locked_q, first_q, timeout_q;
  logic [3:0]        good_run_q, bad_run_q;
  logic [SEQ_W-1:0]  exp_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [31:0]       frame_cnt_q;
  logic [15:0]       err_cnt_q;

  logic              s1_valid_q, s1_pat_ok_q;
  logic [SEQ_W-1:0]  s1_seq_q, s1_exp_q;

  logic [SEQ_W-1:0]   in_seq, exp_adv, in_exp;
  logic [FRAME_W-1:0] in_pattern;
  logic               in_pat_ok, frame_good, count_en, to_fire;

  // The payload is checked against the frame's own seq; the seq itself is compared in stage 2.
  assign in_seq     = data_in[FRAME_W-1 -: SEQ_W];
  assign in_pattern = expected_frame(in_seq);
  assign in_pat_ok  = (data_in == in_pattern);

  // Expected seq advances per frame: +1 in LOCKED, received+1 otherwise. When a frame is still
  // in stage 1, forward its advance so a back-to-back frame is compared against the right seq.
  assign exp_adv = (state_q == ST_LOCKED) ? s1_exp_q + SEQ_W'(1) : s1_seq_q + SEQ_W'(1);
  assign in_exp  = s1_valid_q ? exp_adv : exp_q;

  assign frame_good = s1_pat_ok_q && (first_q || (s1_seq_q == s1_exp_q));
  assign count_en   = s1_valid_q && (state_q == ST_LOCKED);
  assign to_fire    = (state_q == ST_LOCKED) && !data_valid && (to_cnt_q == TO_LAST);

  // Stage 1: capture the frame strobe, seq, expected seq and payload verdict
  always_ff @(posedge clk160) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_pat_ok_q <= 1'b0;
      s1_seq_q    <= '0;
      s1_exp_q    <= '0;
    end else begin
      s1_valid_q <= data_valid;
      if (data_valid) begin
        s1_pat_ok_q <= in_pat_ok;
        s1_seq_q    <= in_seq;
        s1_exp_q    <= in_exp;
      end
    end
  end

  // Stage 2: hunt/lock FSM, timeout watchdog and frame/error counters
  always_ff @(posedge clk160) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      locked_q    <= 1'b0;
      first_q     <= 1'b0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      exp_q       <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (s1_valid_q) exp_q <= exp_adv;

      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_HUNT;
          first_q    <= 1'b1;
          good_run_q <= '0;
        end
        ST_HUNT: begin
          if (s1_valid_q) begin
            first_q <= 1'b0;
            if (!frame_good) begin
              good_run_q <= '0;
            end else if (good_run_q == LOCK_LAST) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              good_run_q <= '0;
              bad_run_q  <= '0;
            end else begin
              good_run_q <= good_run_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (s1_valid_q) begin
            if (frame_good) begin
              bad_run_q <= '0;
            end else if (bad_run_q == UNLOCK_LAST) begin
              state_q    <= ST_HUNT;
              locked_q   <= 1'b0;
              first_q    <= 1'b1;
              bad_run_q  <= '0;
              good_run_q <= '0;
            end else begin
              bad_run_q <= bad_run_q + 4'd1;
            end
          end else if (to_fire) begin
            state_q    <= ST_HUNT;
            locked_q   <= 1'b0;
            first_q    <= 1'b1;
            good_run_q <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase

      // Idle-cycle counter only runs while LOCKED, so it restarts on lock entry
      if (data_valid || (state_q != ST_LOCKED) || to_fire) to_cnt_q <= '0;
      else                                                 to_cnt_q <= to_cnt_q + TO_W'(1);

      if (clear_cnt) begin
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        timeout_q   <= 1'b0;
      end else begin
        if (to_fire) timeout_q <= 1'b1;
        if (count_en) begin
          if (frame_cnt_q != '1)                err_cnt_q   <= err_cnt_q;
          if (frame_cnt_q != '1)                frame_cnt_q <= frame_cnt_q + 32'd1;
          if (!frame_good && (err_cnt_q != '1)) err_cnt_q   <= err_cnt_q + 16'd1;
        end
      end
    end
  end

  assign state         = state_q;
  assign locked        = locked_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_frame_cnt = err_cnt_q;
  assign timeout       = timeout_q;

`ifdef STRIP_CHECK_BITERR_EN
  logic [FRAME_W-1:0] in_xor, s1_frame_q, last_err_q;
  logic [6:0]         pc_cnt;
  logic               s2_add_q;
  logic [31:0]        bit_err_q;
  logic [32:0]        bit_sum;

  assign in_xor  = data_in ^ expected_frame(in_exp);
  assign bit_sum = {1'b0, bit_err_q} + {26'd0, pc_cnt};

  strip_popcount104 u_popcount (
    .clk_i   (clk160),
    .reset_i (reset),
    .vec_i   (in_xor),
    .cnt_o   (pc_cnt)
  );

  // Stage 3: accumulate bit errors of bad LOCKED frames and keep the latest bad frame
  always_ff @(posedge clk160) begin
    if (reset) begin
      s1_frame_q <= '0;
      s2_add_q   <= 1'b0;
      bit_err_q  <= '0;
      last_err_q <= '0;
    end else begin
      if (data_valid) s1_frame_q <= data_in;
      s2_add_q <= count_en && !frame_good && !clear_cnt;
      if (clear_cnt) begin
        bit_err_q  <= '0;
        last_err_q <= '0;
      end else begin
        if (s2_add_q)               bit_err_q  <= bit_sum[32] ? '1 : bit_sum[31:0];
        if (count_en && !frame_good) last_err_q <= s1_frame_q;
      end
    end
  end

  assign bit_err_cnt    = bit_err_q;
  assign last_err_frame = last_err_q;
`else
  assign bit_err_cnt    = '0;
  assign last_err_frame = '0;
`endif

endmodule

// File: tb/tb_strip_frame_checker.sv
// tb/tb_strip_frame_checker.sv - directed self-checking bench for strip_frame_checker
module tb_strip_frame_checker;

`ifdef STRIP_CHECK_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  logic         clk160 = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid = 1'b0;
  logic [103:0] data_in = '0;
  logic         clear_cnt = 1'b0;
  logic [1:0]   state;
  logic         locked;
  logic [31:0]  frame_cnt;
  logic [15:0]  err_frame_cnt;
  logic [31:0]  bit_err_cnt;
  logic         timeout;
  logic [103:0] last_err_frame;

  int n_checks = 0;
  int n_errors = 0;

  strip_frame_checker #(
    .LOCK_CNT   (4),
    .UNLOCK_CNT (15),
    .TIMEOUT    (64)
  ) dut (
    .clk160         (clk160),
    .reset          (reset),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .clear_cnt      (clear_cnt),
    .state          (state),
    .locked         (locked),
    .frame_cnt      (frame_cnt),
    .err_frame_cnt  (err_frame_cnt),
    .bit_err_cnt    (bit_err_cnt),
    .timeout        (timeout),
    .last_err_frame (last_err_frame)
  );

  always #5 clk160 = ~clk160;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mk_frame(input logic [7:0] s);
    logic [103:0] f;
    f[103:96] = s;
    for (int k = 0; k < 12; k++) f[8*k +: 8] = s + 8'(k + 1);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk160);
    #1;
  endtask

  task automatic send(input logic [103:0] f, input int gap);
    data_valid = 1'b1;
    data_in    = f;
    tick();
    data_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_clear();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
  endtask

  initial begin
    logic [103:0] f;
    logic [7:0]   sq;
    int           bexp;
    int           nbad;
    int           nfr;

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    check("rst_state",   128'(state), 128'(0));
    check("rst_locked",  128'(locked), 128'(0));
    check("rst_frames",  128'(frame_cnt), 128'(0));
    check("rst_errs",    128'(err_frame_cnt), 128'(0));
    check("rst_biterr",  128'(bit_err_cnt), 128'(0));
    check("rst_timeout", 128'(timeout), 128'(0));
    check("rst_last",    128'(last_err_frame), 128'(0));
    reset = 1'b0;
    tick();
    check("idle_to_hunt", 128'(state), 128'(1));

    // Lock on 0x10..0x13, exact N+2 latency on the 4th frame
    for (int i = 0; i < 3; i++) send(mk_frame(8'h10 + 8'(i)), 3);
    send(mk_frame(8'h13), 0);
    check("lock_n1", 128'(locked), 128'(0));
    tick();
    check("lock_n2_locked", 128'(locked), 128'(1));
    check("lock_n2_state",  128'(state), 128'(2));
    repeat (2) tick();
    send(mk_frame(8'h14), 3);
    send(mk_frame(8'h15), 3);
    check("lock_frames", 128'(frame_cnt), 128'(2));
    check("lock_errs",   128'(err_frame_cnt), 128'(0));

    // Single bit error on bit 5
    f = mk_frame(8'h16);
    f[5] = ~f[5];
    send(f, 0);
    tick();
    check("err1_errs",   128'(err_frame_cnt), 128'(1));
    check("err1_frames", 128'(frame_cnt), 128'(3));
    check("err1_locked", 128'(locked), 128'(1));
    check("err1_bit_n2", 128'(bit_err_cnt), 128'(0));
    tick();
    check("err1_bit_n3", 128'(bit_err_cnt), BITERR ? 128'(1) : 128'(0));
    check("err1_last",   128'(last_err_frame), BITERR ? 128'(f) : 128'(0));
    tick();
    send(mk_frame(8'h17), 3);
    check("no_cascade_errs",   128'(err_frame_cnt), 128'(1));
    check("no_cascade_frames", 128'(frame_cnt), 128'(4));

    // Clear keeps state
    pulse_clear();
    check("clr_frames", 128'(frame_cnt), 128'(0));
    check("clr_errs",   128'(err_frame_cnt), 128'(0));
    check("clr_bit",    128'(bit_err_cnt), 128'(0));
    check("clr_last",   128'(last_err_frame), 128'(0));
    check("clr_locked", 128'(locked), 128'(1));

    // Unlock: UNLOCK_CNT consecutive wrong-seq frames, expected seq keeps advancing
    bexp = 0;
    for (int i = 0; i < 14; i++) begin
      send(mk_frame(8'h80 + 8'(i)), 3);
      bexp += $countones(mk_frame(8'h80 + 8'(i)) ^ mk_frame(8'h18 + 8'(i)));
    end
    check("unlock_14_locked", 128'(locked), 128'(1));
    send(mk_frame(8'h8E), 3);
    bexp += $countones(mk_frame(8'h8E) ^ mk_frame(8'h26));
    check("unlock_state",  128'(state), 128'(1));
    check("unlock_errs",   128'(err_frame_cnt), 128'(15));
    check("unlock_frames", 128'(frame_cnt), 128'(15));
    check("unlock_bit",    128'(bit_err_cnt), BITERR ? 128'(bexp) : 128'(0));

    // Relock (first frame seq unchecked), then timeout on the 64th idle cycle
    for (int i = 0; i < 4; i++) send(mk_frame(8'h20 + 8'(i)), 3);
    check("relock", 128'(locked), 128'(1));
    send(mk_frame(8'h24), 0);
    repeat (63) tick();
    check("to_before",       128'(timeout), 128'(0));
    check("to_before_state", 128'(state), 128'(2));
    tick();
    check("to_fired",       128'(timeout), 128'(1));
    check("to_fired_state", 128'(state), 128'(1));
    pulse_clear();
    check("to_cleared",       128'(timeout), 128'(0));
    check("to_cleared_state", 128'(state), 128'(1));

    // Lock across the seq wrap
    for (int i = 0; i < 4; i++) send(mk_frame(8'hFB + 8'(i)), 3);
    send(mk_frame(8'hFF), 3);
    send(mk_frame(8'h00), 3);
    send(mk_frame(8'h01), 3);
    check("wrap_locked", 128'(locked), 128'(1));
    check("wrap_frames", 128'(frame_cnt), 128'(3));
    check("wrap_errs",   128'(err_frame_cnt), 128'(0));
    check("wrap_bit",    128'(bit_err_cnt), 128'(0));

    // Saturate err_frame_cnt with back-to-back runs of 14 bad + 1 good frame
    pulse_clear();
    sq = 8'h02;
    nbad = 0;
    nfr = 0;
    while (nbad < 65540) begin
      for (int i = 0; i < 14 && nbad < 65540; i++) begin
        f = mk_frame(sq);
        f[0] = ~f[0];
        data_valid = 1'b1;
        data_in = f;
        tick();
        sq++;
        nbad++;
        nfr++;
      end
      data_valid = 1'b1;
      data_in = mk_frame(sq);
      tick();
      sq++;
      nfr++;
    end
    data_valid = 1'b0;
    repeat (3) tick();
    check("sat_errs",   128'(err_frame_cnt), 128'(16'hFFFF));
    check("sat_frames", 128'(frame_cnt), 128'(nfr));
    check("sat_bit",    128'(bit_err_cnt), BITERR ? 128'(nbad) : 128'(0));
    check("sat_locked", 128'(locked), 128'(1));

    // clear_cnt coincident with a bad frame's stage-2 update
    f = mk_frame(sq);
    f[9] = ~f[9];
    sq++;
    data_valid = 1'b1;
    data_in = f;
    tick();
    data_valid = 1'b0;
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    check("sim_frames", 128'(frame_cnt), 128'(0));
    check("sim_errs",   128'(err_frame_cnt), 128'(0));
    tick();
    check("sim_bit_n3",  128'(bit_err_cnt), 128'(0));
    check("sim_errs_n3", 128'(err_frame_cnt), 128'(0));
    check("sim_last",    128'(last_err_frame), 128'(0));
    check("sim_locked",  128'(locked), 128'(1));

    // Reset with a frame in flight
    send(mk_frame(sq), 3);
    sq++;
    send(mk_frame(sq), 3);
    sq++;
    check("pre_rst_frames", 128'(frame_cnt), 128'(2));
    data_valid = 1'b1;
    data_in = mk_frame(sq);
    tick();
    data_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_state",  128'(state), 128'(0));
    check("mid_rst_locked", 128'(locked), 128'(0));
    check("mid_rst_frames", 128'(frame_cnt), 128'(0));
    check("mid_rst_errs",   128'(err_frame_cnt), 128'(0));
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_state",  128'(state), 128'(1));
    check("post_rst_frames", 128'(frame_cnt), 128'(0));
    check("post_rst_bit",    128'(bit_err_cnt), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/strip_frame_checker.md
# strip_frame_checker

Consumes the 104-bit strip frames and frame-valid strobe produced by the strip data alignment stage on clk160. Checks each frame against the strip test pattern and tracks pattern lock with a hunt/lock state machine. Keeps saturating frame, error and bit-error counters for link qualification from the debug VIO/ILA.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive good frames needed to lock (1..15).
- UNLOCK_CNT, 4: consecutive bad frames that drop lock (1..15).
- TIMEOUT, 64: clk160 cycles without a frame while LOCKED before timeout (≥8).

Ports (clk160 and reset are one clock; reset is synchronous, active-high):
- clk160  in  1  system clock, 160 MHz.
- reset  in  1  synchronous active-high reset.
- data_valid  in  1  one-cycle frame strobe from the upstream stage.
- data_in  in  104  frame; sampled only when data_valid=1.
- clear_cnt  in  1  pulse; zeroes all counters and the timeout flag.
- state  out  2  0=IDLE, 1=HUNT, 2=LOCKED.
- locked  out  1  state==LOCKED.
- frame_cnt  out  32  frames checked while LOCKED; saturates at 0xFFFFFFFF.
- err_frame_cnt  out  16  mismatching frames while LOCKED; saturates at 0xFFFF.
- bit_err_cnt  out  32  mismatching bits while LOCKED; saturates.
- timeout  out  1  sticky; set on a LOCKED timeout.
- last_err_frame  out  104  most recent mismatching frame received while LOCKED.

## Operation
- Pattern: seq = data_in[103:96]. Byte k of data_in[95:0] (k=0 at [7:0]) must equal (seq+k+1) mod 256. Sequence advances by 1 mod 256 per frame.
- expected_seq: loaded with received seq+1 on every frame in HUNT. Increments by 1 on every frame in LOCKED, good or bad, so a single corruption does not cascade.
- A frame is good when its seq equals expected_seq and all 12 bytes match. In HUNT, seq is not compared on the first frame after entry.
- IDLE: entered on reset. Goes to HUNT on the first cycle after reset deasserts.
- HUNT: counts consecutive good frames. A bad frame resets the count to 0 and reloads expected_seq. Reaching LOCK_CNT goes to LOCKED.
- LOCKED:
  - Every frame increments frame_cnt.
  - A bad frame increments err_frame_cnt, adds popcount(data_in XOR expected frame) to bit_err_cnt, and captures last_err_frame.
  - UNLOCK_CNT consecutive bad frames go to HUNT.
  - TIMEOUT cycles with no data_valid set timeout and go to HUNT.
- Counters change only in LOCKED; HUNT frames are not counted.
- Saturation: a counter at maximum holds. An addition that would overflow bit_err_cnt clamps to maximum.
- clear_cnt: zeroes counters, timeout and last_err_frame the cycle after assertion. State is unaffected.
- clear_cnt together with a counting update: clear wins and that frame's contribution is dropped.
- reset mid-operation: all outputs return to reset values the next cycle. Any in-flight pipeline frame is discarded.
- Reset values: state=0, locked=0, all counters 0, timeout=0, last_err_frame=0.

## Timing
- Stage 1, cycle after data_valid: input register holding frame, valid, and the XOR vector against the expected frame.
- Stage 2: good/bad decision, state transition and frame/err_frame counter update.
- bit_err_cnt updates one cycle later still, in stage 3, through the pipelined popcount.
- Latency: data_valid at cycle N → state/frame_cnt/err_frame_cnt visible at N+2, bit_err_cnt at N+3.
- Frame rate: back-to-back data_valid on every cycle is accepted with no drops. The upstream stage nominally delivers one frame per 4 cycles.
- Timeout counter: restarts on every data_valid and on entering LOCKED. Timeout fires on the TIMEOUT-th idle cycle.

## Configuration
- STRIP_CHECK_BITERR_EN defined:
  - popcount pipeline and bit_err_cnt are built.
  - last_err_frame captures frames.
- Not defined:
  - bit_err_cnt and last_err_frame are constant 0; the popcount logic is removed.
  - Lock behaviour and the other counters are unchanged.

## Structure
- Package strip_check_pkg holds:
  - state encoding constants (IDLE/HUNT/LOCKED);
  - FRAME_W=104 and SEQ_W=8;
  - an expected_frame(seq) function.
- Sub-module strip_popcount104: a two-stage registered popcount of a 104-bit vector with 7-bit result. It is instantiated only under STRIP_CHECK_BITERR_EN.

## Test plan
- Lock: reset, then 6 correct frames seq 0x10..0x15, one per 4 cycles. Expect locked after the 4th (seq 0x13) at N+2, and frame_cnt=2.
- Single error: after lock, send a frame with data_in[5]=1 flipped. Expect err_frame_cnt=1, bit_err_cnt=1 (macro on), last_err_frame equal to that frame, and locked remains 1.
- Unlock: after lock, send 4 consecutive frames with wrong seq. Expect state=HUNT after the 4th and err_frame_cnt=4.
- Timeout: after lock, hold data_valid=0 for 64 cycles. Expect timeout=1 and state=HUNT; clear_cnt then zeroes timeout.
- Wrap/saturate: lock across seq 0xFE,0xFF,0x00 and expect no errors. Force err_frame_cnt to 0xFFFF via a bad frame stream and expect it to hold.
- Simultaneous: clear_cnt in the same cycle as a bad frame's stage-2 update. Expect all counters 0 the next cycle; then reset mid-frame and expect reset values with no counter change.
